// File: rtl/condition_pkg.sv
// Shared definitions for the condition block and its hardware self-check engine.
package condition_pkg;

    localparam int SEL_W_DEF  = 2;
    localparam int DATA_W_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_e;

endpackage

// File: rtl/condition_cmp.sv
// Combinational mismatch detector across the condition block's output variants.
module condition_cmp
    import condition_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter bit CHECK_LATCH = 1'b1
)(
    input  logic [DATA_W-1:0] normal_if_i,
    input  logic [DATA_W-1:0] normal_case_i,
    input  logic [DATA_W-1:0] normal_ternary_i,
    input  logic [DATA_W-1:0] latch_if_i,
    input  logic [DATA_W-1:0] latch_case_i,
    output logic              mismatch_o
);

    logic normal_diff;
    logic latch_diff;

    assign normal_diff = (normal_if_i != normal_case_i) || (normal_if_i != normal_ternary_i);
    assign latch_diff  = CHECK_LATCH && (latch_if_i != latch_case_i);
    assign mismatch_o  = normal_diff || latch_diff;

endmodule

// File: rtl/condition_checker.sv
// Sweeps sel over every code, samples the condition block after a settle window and
// counts vectors where the coding variants disagree.
//   state  | meaning
//   IDLE   | waiting for start; results of last run held
//   DRIVE  | sel_o stable for this vector; load settle counter
//   SETTLE | count down the settle window
//   SAMPLE | compare registered inputs, update counters, advance sel
//   DONE   | one-cycle done pulse; latch pass
module condition_checker
    import condition_pkg::*;
#(
    parameter int SEL_W         = SEL_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int SETTLE_CYCLES = 2,
    parameter int SWEEPS        = 2,
    parameter bit CHECK_LATCH   = 1'b1,
    parameter int CNT_W         = 8
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [SEL_W-1:0]  sel_o,
    input  logic [DATA_W-1:0] normal_if_i,
    input  logic [DATA_W-1:0] normal_case_i,
    input  logic [DATA_W-1:0] normal_ternary_i,
    input  logic [DATA_W-1:0] latch_if_i,
    input  logic [DATA_W-1:0] latch_case_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  vec_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              first_err_valid,
    output logic [SEL_W-1:0]  first_err_sel
);

    localparam int              NVEC        = SWEEPS * (2 ** SEL_W);
    localparam int              IDX_W       = (NVEC > 1) ? $clog2(NVEC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NVEC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [3:0]         settle_q, settle_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               fev_q, fev_d;
    logic [SEL_W-1:0]   fes_q, fes_d;
    logic               pass_q, pass_d;

    // Inputs are registered every cycle so the compare sees a clean, synchronous snapshot.
    logic [DATA_W-1:0]  nif_q, ncase_q, ntern_q, lif_q, lcase_q;
    logic               mismatch;

    condition_cmp #(
        .DATA_W      (DATA_W),
        .CHECK_LATCH (CHECK_LATCH)
    ) u_cmp (
        .normal_if_i      (nif_q),
        .normal_case_i    (ncase_q),
        .normal_ternary_i (ntern_q),
        .latch_if_i       (lif_q),
        .latch_case_i     (lcase_q),
        .mismatch_o       (mismatch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            settle_q  <= '0;
            idx_q     <= '0;
            vec_cnt_q <= '0;
            err_cnt_q <= '0;
            fev_q     <= 1'b0;
            fes_q     <= '0;
            pass_q    <= 1'b0;
            nif_q     <= '0;
            ncase_q   <= '0;
            ntern_q   <= '0;
            lif_q     <= '0;
            lcase_q   <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            settle_q  <= settle_d;
            idx_q     <= idx_d;
            vec_cnt_q <= vec_cnt_d;
            err_cnt_q <= err_cnt_d;
            fev_q     <= fev_d;
            fes_q     <= fes_d;
            pass_q    <= pass_d;
            nif_q     <= normal_if_i;
            ncase_q   <= normal_case_i;
            ntern_q   <= normal_ternary_i;
            lif_q     <= latch_if_i;
            lcase_q   <= latch_case_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        settle_d  = settle_q;
        idx_d     = idx_q;
        vec_cnt_d = vec_cnt_q;
        err_cnt_d = err_cnt_q;
        fev_d     = fev_q;
        fes_d     = fes_q;
        pass_d    = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = DRIVE;
                    sel_d     = '0;
                    idx_d     = '0;
                    vec_cnt_d = '0;
                    err_cnt_d = '0;
                    fev_d     = 1'b0;
                    fes_d     = '0;
                    pass_d    = 1'b0;
                end
            end
            DRIVE: begin
                settle_d = SETTLE_LOAD;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            SAMPLE: begin
                if (vec_cnt_q != CNT_MAX) begin
                    vec_cnt_d = vec_cnt_q + 1'b1;
                end
                if (mismatch) begin
                    if (err_cnt_q != CNT_MAX) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (!fev_q) begin
                        fev_d = 1'b1;
                        fes_d = sel_q;
                    end
                end
                // The vector index never saturates, so run length is independent of CNT_W.
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    state_d = DRIVE;
                    sel_d   = sel_q + 1'b1;
                    idx_d   = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                pass_d  = (err_cnt_q == '0);
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_o           = sel_q;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign pass            = pass_q;
    assign vec_cnt         = vec_cnt_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_valid = fev_q;
    assign first_err_sel   = fes_q;

endmodule

// File: tb/tb_condition_checker.sv
// Self-checking bench: behavioural condition block with fault injection driving three
// checker instances (default, latch compare disabled, 2-bit counters).
module tb_condition_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;

    logic [1:0] nif, ncase, ntern, lif, lcase;
    logic [1:0] flt [5][4];
    logic       force_lcase = 1'b0;

    logic [1:0] sel_a, fes_a, sel_b, fes_b, sel_c, fes_c;
    logic       busy_a, done_a, pass_a, fev_a;
    logic       busy_b, done_b, pass_b, fev_b;
    logic       busy_c, done_c, pass_c, fev_c;
    logic [7:0] vec_a, err_a, vec_b, err_b;
    logic [1:0] vec_c, err_c;

    int checks = 0;
    int failures = 0;
    int obs_done_cyc, obs_ndone, obs_ndone_c, obs_busy_first, obs_busy_after;
    int m_vec, m_err, m_fev, m_fes;

    always #5 clk = ~clk;

    function automatic logic [1:0] nom(input logic [1:0] s);
        return {s[0], s[1]} ^ 2'b10;
    endfunction

    assign nif   = nom(sel_a) ^ flt[0][sel_a];
    assign ncase = nom(sel_a) ^ flt[1][sel_a];
    assign ntern = nom(sel_a) ^ flt[2][sel_a];
    assign lif   = sel_a ^ flt[3][sel_a];
    assign lcase = force_lcase ? 2'd3 : (sel_a ^ flt[4][sel_a]);

    condition_checker u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel_o(sel_a),
        .normal_if_i(nif), .normal_case_i(ncase), .normal_ternary_i(ntern),
        .latch_if_i(lif), .latch_case_i(lcase),
        .busy(busy_a), .done(done_a), .pass(pass_a), .vec_cnt(vec_a), .err_cnt(err_a),
        .first_err_valid(fev_a), .first_err_sel(fes_a)
    );

    condition_checker #(.CHECK_LATCH(1'b0)) u_nolatch (
        .clk(clk), .rst_n(rst_n), .start(start), .sel_o(sel_b),
        .normal_if_i(nif), .normal_case_i(ncase), .normal_ternary_i(ntern),
        .latch_if_i(lif), .latch_case_i(lcase),
        .busy(busy_b), .done(done_b), .pass(pass_b), .vec_cnt(vec_b), .err_cnt(err_b),
        .first_err_valid(fev_b), .first_err_sel(fes_b)
    );

    condition_checker #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .sel_o(sel_c),
        .normal_if_i(nif), .normal_case_i(ncase), .normal_ternary_i(ntern),
        .latch_if_i(lif), .latch_case_i(lcase),
        .busy(busy_c), .done(done_c), .pass(pass_c), .vec_cnt(vec_c), .err_cnt(err_c),
        .first_err_valid(fev_c), .first_err_sel(fes_c)
    );

    task automatic clear_faults();
        for (int k = 0; k < 5; k++)
            for (int s = 0; s < 4; s++)
                flt[k][s] = 2'b00;
        force_lcase = 1'b0;
    endtask

    // Whole-run reference: 2 sweeps x 4 codes, mismatch rule applied per vector, then saturation.
    task automatic model_run(input bit chk_latch, input int cnt_w);
        int e;
        int sat;
        logic [1:0] s, a, b, c, d, f;
        e = 0; m_fev = 0; m_fes = 0;
        for (int v = 0; v < 8; v++) begin
            s = 2'(v % 4);
            a = nom(s) ^ flt[0][s];
            b = nom(s) ^ flt[1][s];
            c = nom(s) ^ flt[2][s];
            d = s ^ flt[3][s];
            f = force_lcase ? 2'd3 : (s ^ flt[4][s]);
            if (a != b || a != c || (chk_latch && d != f)) begin
                e++;
                if (m_fev == 0) begin m_fev = 1; m_fes = int'(s); end
            end
        end
        sat = (1 << cnt_w) - 1;
        m_vec = (8 > sat) ? sat : 8;
        m_err = (e > sat) ? sat : e;
    endtask

    // Start one run and observe it for a fixed 45-cycle window.
    task automatic run_dut(input int pulse_at);
        int cyc;
        cyc = 0;
        obs_done_cyc = 0; obs_ndone = 0; obs_ndone_c = 0; obs_busy_first = 0; obs_busy_after = 1;
        @(negedge clk);
        start = 1'b1;
        while (cyc < 45) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin start = 1'b0; obs_busy_first = int'(busy_a); end
            if (cyc == pulse_at) start = 1'b1;
            if (cyc == pulse_at + 1) start = 1'b0;
            if (done_a) begin obs_ndone++; if (obs_done_cyc == 0) obs_done_cyc = cyc; end
            if (done_c) obs_ndone_c++;
            if (obs_done_cyc != 0 && cyc == obs_done_cyc + 1) obs_busy_after = int'(busy_a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({busy_a, done_a, pass_a, fev_a} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy_a, done_a, pass_a, fev_a}); end
        checks++; if ({vec_a, err_a} !== 16'h0000) begin failures++; $display("FAIL reset_counts got vec=%0d err=%0d exp 0 0", vec_a, err_a); end
        checks++; if ({sel_a, fes_a} !== 4'b0000) begin failures++; $display("FAIL reset_sel got sel=%0d fes=%0d exp 0 0", sel_a, fes_a); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean();
        clear_faults();
        run_dut(0);
        checks++; if (obs_done_cyc !== 33) begin failures++; $display("FAIL clean_done_cycle got=%0d exp=33", obs_done_cyc); end
        checks++; if (obs_ndone !== 1) begin failures++; $display("FAIL clean_done_pulses got=%0d exp=1", obs_ndone); end
        checks++; if (obs_busy_first !== 1) begin failures++; $display("FAIL clean_busy_start got=%0d exp=1", obs_busy_first); end
        checks++; if (obs_busy_after !== 0) begin failures++; $display("FAIL clean_busy_after_done got=%0d exp=0", obs_busy_after); end
        checks++; if (vec_a !== 8'd8) begin failures++; $display("FAIL clean_vec_cnt got=%0d exp=8", vec_a); end
        checks++; if (err_a !== 8'd0) begin failures++; $display("FAIL clean_err_cnt got=%0d exp=0", err_a); end
        checks++; if ({pass_a, fev_a} !== 2'b10) begin failures++; $display("FAIL clean_pass_fev got=%b exp=10", {pass_a, fev_a}); end
    endtask

    task automatic test_ternary_sel2();
        clear_faults();
        flt[2][2] = 2'b01;
        run_dut(0);
        checks++; if (err_a !== 8'd2) begin failures++; $display("FAIL tern_err_cnt got=%0d exp=2", err_a); end
        checks++; if (fes_a !== 2'd2) begin failures++; $display("FAIL tern_first_sel got=%0d exp=2", fes_a); end
        checks++; if ({fev_a, pass_a} !== 2'b10) begin failures++; $display("FAIL tern_fev_pass got=%b exp=10", {fev_a, pass_a}); end
    endtask

    task automatic test_latch();
        clear_faults();
        force_lcase = 1'b1;
        run_dut(0);
        checks++; if (err_a !== 8'd6) begin failures++; $display("FAIL latch_err_cnt got=%0d exp=6", err_a); end
        checks++; if (fes_a !== 2'd0) begin failures++; $display("FAIL latch_first_sel got=%0d exp=0", fes_a); end
        checks++; if (err_b !== 8'd0) begin failures++; $display("FAIL latch_off_err_cnt got=%0d exp=0", err_b); end
        checks++; if ({pass_b, fev_b} !== 2'b10) begin failures++; $display("FAIL latch_off_pass_fev got=%b exp=10", {pass_b, fev_b}); end
    endtask

    task automatic test_restart_ignored();
        clear_faults();
        run_dut(10);
        checks++; if (obs_done_cyc !== 33) begin failures++; $display("FAIL restart_done_cycle got=%0d exp=33", obs_done_cyc); end
        checks++; if (obs_ndone !== 1) begin failures++; $display("FAIL restart_done_pulses got=%0d exp=1", obs_ndone); end
        checks++; if (vec_a !== 8'd8) begin failures++; $display("FAIL restart_vec_cnt got=%0d exp=8", vec_a); end
    endtask

    task automatic test_reset_midrun();
        clear_faults();
        flt[1][1] = 2'b10;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({busy_a, done_a, pass_a, fev_a, sel_a} !== 6'b0) begin failures++; $display("FAIL midrst_flags got=%b exp=000000", {busy_a, done_a, pass_a, fev_a, sel_a}); end
        checks++; if ({vec_a, err_a} !== 16'h0000) begin failures++; $display("FAIL midrst_counts got vec=%0d err=%0d exp 0 0", vec_a, err_a); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_faults();
        run_dut(0);
        checks++; if (obs_done_cyc !== 33) begin failures++; $display("FAIL midrst_rerun_done got=%0d exp=33", obs_done_cyc); end
        checks++; if ({vec_a, err_a} !== {8'd8, 8'd0}) begin failures++; $display("FAIL midrst_rerun_counts got vec=%0d err=%0d exp 8 0", vec_a, err_a); end
    endtask

    task automatic test_saturate();
        clear_faults();
        for (int s = 0; s < 4; s++) flt[1][s] = 2'b01;
        run_dut(0);
        checks++; if (err_c !== 2'd3) begin failures++; $display("FAIL sat_err_cnt got=%0d exp=3", err_c); end
        checks++; if (vec_c !== 2'd3) begin failures++; $display("FAIL sat_vec_cnt got=%0d exp=3", vec_c); end
        checks++; if (obs_ndone_c !== 1) begin failures++; $display("FAIL sat_done_pulses got=%0d exp=1", obs_ndone_c); end
        checks++; if (err_a !== 8'd8) begin failures++; $display("FAIL sat_wide_err_cnt got=%0d exp=8", err_a); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            clear_faults();
            for (int k = 0; k < 5; k++)
                for (int s = 0; s < 4; s++)
                    if ($urandom_range(0, 5) == 0) flt[k][s] = 2'($urandom_range(1, 3));
            force_lcase = ($urandom_range(0, 7) == 0);
            run_dut(0);
            model_run(1'b1, 8);
            checks++; if (int'(err_a) !== m_err) begin failures++; $display("FAIL rand%0d_err got=%0d exp=%0d", it, err_a, m_err); end
            checks++; if (int'(fev_a) !== m_fev) begin failures++; $display("FAIL rand%0d_fev got=%0d exp=%0d", it, fev_a, m_fev); end
            checks++; if (int'(fes_a) !== m_fes) begin failures++; $display("FAIL rand%0d_fes got=%0d exp=%0d", it, fes_a, m_fes); end
            checks++; if (int'(pass_a) !== int'(m_err == 0)) begin failures++; $display("FAIL rand%0d_pass got=%0d exp=%0d", it, pass_a, m_err == 0); end
            model_run(1'b0, 8);
            checks++; if (int'(err_b) !== m_err) begin failures++; $display("FAIL rand%0d_nolatch_err got=%0d exp=%0d", it, err_b, m_err); end
            model_run(1'b1, 2);
            checks++; if ({int'(vec_c), int'(err_c)} !== {m_vec, m_err}) begin failures++; $display("FAIL rand%0d_sat got vec=%0d err=%0d exp %0d %0d", it, vec_c, err_c, m_vec, m_err); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit seen;
        clear_faults();
        @(negedge clk);
        start = 1'b1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            seen = done_a;
        end
        checks++; if (!seen) begin failures++; $display("FAIL b2b_first_done got=timeout exp=done"); end
        @(posedge clk); #1;
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap got=%0d exp=0", busy_a); end
        @(posedge clk); #1;
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL b2b_restart got=%0d exp=1", busy_a); end
        start = 1'b0;
        cyc = 1; seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            seen = done_a;
        end
        checks++; if (cyc !== 33) begin failures++; $display("FAIL b2b_second_done_cycle got=%0d exp=33", cyc); end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        clear_faults();
        test_reset();
        test_clean();
        test_ternary_sel2();
        test_latch();
        test_restart_ignored();
        test_reset_midrun();
        test_saturate();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
